raster_scheduler: RTL and testbench
===================================

Name: raster_scheduler

Overview:
Front-end controller for rasterizer_unit.
- Queues triangle commands from the geometry stage in a small FIFO.
- Sequences the rasterizer one triangle at a time with a start pulse and waits for done.
- Owns the shared framebuffer/z-buffer write ports, muxing them between the rasterizer and a built-in frame-clear sweep that writes background color and far depth.

Parameters:
QUEUE_DEPTH, 4, triangle FIFO entries (power of two, >=2)
FB_WIDTH, 320, clear sweep width in pixels
FB_HEIGHT, 240, clear sweep height in pixels
CLEAR_COLOR, 4'h0, fb_data written during clear
CLEAR_DEPTH, 8'hFF, zb_wdata written during clear

Ports:
clk  in  1  system clock, all logic on rising edge
sreset  in  1  synchronous active-high reset, shared with rasterizer_unit
tri_valid  in  1  triangle command valid
tri_ready  out  1  FIFO can accept (= not full)
tri_p1, tri_p2, tri_p3  in  3x32 each  vertex x,y,z, IEEE-754 single
tri_color  in  4  triangle color
clear_req  in  1  single-cycle request to clear frame and depth
frame_busy  out  1  work outstanding
tri_count  out  16  triangles completed since reset, wraps
ru_start  out  1  start pulse to rasterizer
ru_p1, ru_p2, ru_p3  out  3x32 each  vertices to rasterizer
ru_color  out  4  color to rasterizer
ru_done  in  1  rasterizer finished
ru_fb_we, ru_zb_we  in  1 each  rasterizer write enables
ru_rast_x, ru_rast_y  in  10 each  rasterizer pixel coordinates
ru_fb_data  in  4  rasterizer color data
ru_zb_wdata  in  8  rasterizer depth data
fb_we, zb_we  out  1 each  memory write enables
fb_x, fb_y  out  10 each  memory pixel coordinates
fb_data  out  4  memory color data
zb_wdata  out  8  memory depth data

Behaviour:
- Reset (sreset high at an edge):
  - FIFO emptied; state IDLE; clear_pending=0; tri_count=0.
  - ru_start=0; ru_p*/ru_color=0.
  - Clear counters=0; write ports follow mux rule below.
  - Reset mid-WAIT or mid-CLEAR aborts the operation; no write occurs after the reset edge.
- FIFO push: on an edge where tri_valid&&tri_ready.
  - tri_ready = !full, registered-count based.
  - Push and pop on the same edge are both honoured.
  - Push while full is impossible by construction.
- clear_req sets clear_pending on the edge it is sampled; repeated requests before service merge into one clear.
- States:
  - IDLE:
    - if clear_pending -> CLEAR (clear has priority over queued triangles);
    - else if FIFO non-empty -> LOAD;
    - else stay.
  - CLEAR:
    - Raster scan x=0..FB_WIDTH-1, then y=0..FB_HEIGHT-1, one pixel per cycle.
    - fb_we=zb_we=1; fb_x/fb_y = counters; fb_data=CLEAR_COLOR; zb_wdata=CLEAR_DEPTH.
    - clear_pending cleared on CLEAR entry; a clear_req during CLEAR re-arms it.
    - Lasts exactly FB_WIDTH*FB_HEIGHT cycles.
    - After writing (FB_WIDTH-1, FB_HEIGHT-1) -> IDLE.
  - LOAD: pop FIFO head into ru_p*/ru_color -> START.
  - START: ru_start=1 for exactly this one cycle -> WAIT.
  - WAIT:
    - On ru_done -> IDLE and tri_count+1 (wrap 0xFFFF->0).
    - A clear_req during WAIT is deferred until after done.
- ru_done outside WAIT is ignored.
- ru_p*/ru_color hold stable from LOAD until the next LOAD.
- Latency, push on edge E into an empty FIFO with state IDLE and no clear pending:
  - LOAD after E+1;
  - ru_p* valid and ru_start high between E+2 and E+3.
- Back-to-back: ru_done at edge D with FIFO non-empty gives the next ru_start between D+2 and D+3.
- Write mux (combinational):
  - In CLEAR, the clear engine drives fb_*/zb_*.
  - Otherwise fb_we=ru_fb_we, zb_we=ru_zb_we, fb_x=ru_rast_x, fb_y=ru_rast_y, fb_data=ru_fb_data, zb_wdata=ru_zb_wdata.
  - In CLEAR, ru_* writes are discarded.
- frame_busy = (state!=IDLE) || FIFO non-empty || clear_pending.

Decomposition:
- raster_pkg holds:
  - triangle_t struct (p1, p2, p3 as logic[2:0][31:0], color[3:0]);
  - sched_state_t enum {IDLE, CLEAR, LOAD, START, WAIT};
  - FB_WIDTH/FB_HEIGHT defaults;
  - CLEAR_DEPTH default.
- Sub-module tri_fifo: synchronous FIFO of triangle_t with push/pop/full/empty/count, sreset.
- FSM, clear counters and write mux live in raster_scheduler.

Test Plan:
1. Single triangle: reset; push p1=(-0.5,0.5,0.1), p2=(-0.5,-0.5,0.1), p3=(0.5,0,0.1), color=4'hA at E -> ru_start one cycle between E+2 and E+3 with those values on ru_p*; ru_done 50 cycles later -> tri_count=1, frame_busy=0 next cycle.
2. Queue fill: hold tri_valid with 6 distinct triangles and the rasterizer stalled (no done) -> tri_ready low once 4 entries remain queued; as done pulses arrive, triangles issue in push order; tri_count=6 at end.
3. Clear sweep with FB_WIDTH=8, FB_HEIGHT=4:
   - clear_req in IDLE -> exactly 32 consecutive cycles of fb_we=zb_we=1;
   - coordinates (0,0),(1,0)..(7,3);
   - fb_data=0, zb_wdata=FF;
   - ru_* writes injected during the sweep do not appear.
4. Priority and defer: clear_req during WAIT plus one queued triangle -> clear runs after ru_done and before the next ru_start; two clear_reqs during WAIT -> one sweep.
5. Reset mid-operation: sreset during CLEAR at pixel 10 -> fb_we=0 next cycle, FIFO empty, tri_count=0, state IDLE; no further ru_start.
6. Spurious done and wrap: ru_done in IDLE -> no count change; preload tri_count=16'hFFFF via 65535 completions (or force) -> next done gives 0.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared types and defaults for the raster front-end: triangle record,
// scheduler states and frame-clear defaults.
package raster_pkg;

  localparam int          FB_WIDTH_DEF    = 320;
  localparam int          FB_HEIGHT_DEF   = 240;
  localparam logic [7:0]  CLEAR_DEPTH_DEF = 8'hFF;

  // Each vertex is {z, y, x}, IEEE-754 single precision.
  typedef struct packed {
    logic [2:0][31:0] p1;
    logic [2:0][31:0] p2;
    logic [2:0][31:0] p3;
    logic [3:0]       color;
  } triangle_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    START,
    WAIT
  } sched_state_t;

endpackage

// File: rtl/tri_fifo.sv
// Synchronous FIFO of triangle commands; pushes when full and pops when
// empty are dropped.
module tri_fifo
  import raster_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     sreset,
  input  logic                     push,
  input  logic                     pop,
  input  triangle_t                wdata,
  output triangle_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  triangle_t        mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             wr_en;
  logic             rd_en;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (sreset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (rd_en) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/raster_scheduler.sv
// Rasterizer front-end: queues triangles, sequences rasterizer_unit and
// owns the framebuffer/z-buffer write ports (rasterizer or clear sweep).
//
// state | meaning
// IDLE  | waiting for a pending clear or a queued triangle
// CLEAR | sweeping background color / far depth, one pixel per cycle
// LOAD  | popping FIFO head into the rasterizer operand registers
// START | one-cycle start pulse to the rasterizer
// WAIT  | rasterizer busy, waiting for ru_done
module raster_scheduler
  import raster_pkg::*;
#(
  parameter int         QUEUE_DEPTH = 4,
  parameter int         FB_WIDTH    = FB_WIDTH_DEF,
  parameter int         FB_HEIGHT   = FB_HEIGHT_DEF,
  parameter logic [3:0] CLEAR_COLOR = 4'h0,
  parameter logic [7:0] CLEAR_DEPTH = CLEAR_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             sreset,
  input  logic             tri_valid,
  output logic             tri_ready,
  input  logic [2:0][31:0] tri_p1,
  input  logic [2:0][31:0] tri_p2,
  input  logic [2:0][31:0] tri_p3,
  input  logic [3:0]       tri_color,
  input  logic             clear_req,
  output logic             frame_busy,
  output logic [15:0]      tri_count,
  output logic             ru_start,
  output logic [2:0][31:0] ru_p1,
  output logic [2:0][31:0] ru_p2,
  output logic [2:0][31:0] ru_p3,
  output logic [3:0]       ru_color,
  input  logic             ru_done,
  input  logic             ru_fb_we,
  input  logic             ru_zb_we,
  input  logic [9:0]       ru_rast_x,
  input  logic [9:0]       ru_rast_y,
  input  logic [3:0]       ru_fb_data,
  input  logic [7:0]       ru_zb_wdata,
  output logic             fb_we,
  output logic             zb_we,
  output logic [9:0]       fb_x,
  output logic [9:0]       fb_y,
  output logic [3:0]       fb_data,
  output logic [7:0]       zb_wdata
);

  localparam logic [9:0] X_LAST = 10'(FB_WIDTH - 1);
  localparam logic [9:0] Y_LAST = 10'(FB_HEIGHT - 1);

  sched_state_t state_q, state_d;
  logic         clear_pending_q, clear_pending_d;
  logic [9:0]   clr_x_q, clr_x_d;
  logic [9:0]   clr_y_q, clr_y_d;
  logic [15:0]  tri_count_q, tri_count_d;
  triangle_t    ru_tri_q, ru_tri_d;

  triangle_t                     fifo_wdata;
  triangle_t                     fifo_head;
  logic                          fifo_push;
  logic                          fifo_pop;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(QUEUE_DEPTH):0]  fifo_count;

  assign fifo_wdata = '{p1: tri_p1, p2: tri_p2, p3: tri_p3, color: tri_color};
  assign tri_ready  = !fifo_full;
  assign fifo_push  = tri_valid && tri_ready;

  tri_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk    (clk),
    .sreset (sreset),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wdata  (fifo_wdata),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q         <= IDLE;
      clear_pending_q <= 1'b0;
      clr_x_q         <= '0;
      clr_y_q         <= '0;
      tri_count_q     <= '0;
      ru_tri_q        <= '0;
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      clr_x_q         <= clr_x_d;
      clr_y_q         <= clr_y_d;
      tri_count_q     <= tri_count_d;
      ru_tri_q        <= ru_tri_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    clear_pending_d = clear_pending_q;
    clr_x_d         = clr_x_q;
    clr_y_d         = clr_y_q;
    tri_count_d     = tri_count_q;
    ru_tri_d        = ru_tri_q;
    fifo_pop        = 1'b0;
    ru_start        = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_pending_q) begin
          state_d         = CLEAR;
          clear_pending_d = 1'b0;
        end else if (!fifo_empty) begin
          state_d = LOAD;
        end
      end
      CLEAR: begin
        if (clr_x_q == X_LAST) begin
          clr_x_d = '0;
          if (clr_y_q == Y_LAST) begin
            clr_y_d = '0;
            state_d = IDLE;
          end else begin
            clr_y_d = clr_y_q + 10'd1;
          end
        end else begin
          clr_x_d = clr_x_q + 10'd1;
        end
      end
      LOAD: begin
        fifo_pop = 1'b1;
        ru_tri_d = fifo_head;
        state_d  = START;
      end
      START: begin
        ru_start = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (ru_done) begin
          state_d     = IDLE;
          tri_count_d = tri_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A request arriving in any state (including CLEAR or WAIT) leaves one clear pending.
    if (clear_req) begin
      clear_pending_d = 1'b1;
    end
  end

  always_comb begin
    if (state_q == CLEAR) begin
      fb_we    = 1'b1;
      zb_we    = 1'b1;
      fb_x     = clr_x_q;
      fb_y     = clr_y_q;
      fb_data  = CLEAR_COLOR;
      zb_wdata = CLEAR_DEPTH;
    end else begin
      fb_we    = ru_fb_we;
      zb_we    = ru_zb_we;
      fb_x     = ru_rast_x;
      fb_y     = ru_rast_y;
      fb_data  = ru_fb_data;
      zb_wdata = ru_zb_wdata;
    end
  end

  assign ru_p1      = ru_tri_q.p1;
  assign ru_p2      = ru_tri_q.p2;
  assign ru_p3      = ru_tri_q.p3;
  assign ru_color   = ru_tri_q.color;
  assign tri_count  = tri_count_q;
  assign frame_busy = (state_q != IDLE) || (fifo_count != '0) || clear_pending_q;

endmodule

// File: tb/tb_raster_scheduler.sv
// Scoreboard bench for raster_scheduler: stimulus queues expected rasterizer
// launches and clear writes; a negedge monitor pops and compares them.
module tb_raster_scheduler;

  logic             clk = 1'b0;
  logic             sreset;
  logic             tri_valid;
  logic             tri_ready;
  logic [2:0][31:0] tri_p1, tri_p2, tri_p3;
  logic [3:0]       tri_color;
  logic             clear_req;
  logic             frame_busy;
  logic [15:0]      tri_count;
  logic             ru_start;
  logic [2:0][31:0] ru_p1, ru_p2, ru_p3;
  logic [3:0]       ru_color;
  logic             ru_done;
  logic             ru_fb_we, ru_zb_we;
  logic [9:0]       ru_rast_x, ru_rast_y;
  logic [3:0]       ru_fb_data;
  logic [7:0]       ru_zb_wdata;
  logic             fb_we, zb_we;
  logic [9:0]       fb_x, fb_y;
  logic [3:0]       fb_data;
  logic [7:0]       zb_wdata;

  always #5 clk = ~clk;

  raster_scheduler #(
    .QUEUE_DEPTH (4),
    .FB_WIDTH    (8),
    .FB_HEIGHT   (4),
    .CLEAR_COLOR (4'h0),
    .CLEAR_DEPTH (8'hFF)
  ) dut (
    .clk         (clk),
    .sreset      (sreset),
    .tri_valid   (tri_valid),
    .tri_ready   (tri_ready),
    .tri_p1      (tri_p1),
    .tri_p2      (tri_p2),
    .tri_p3      (tri_p3),
    .tri_color   (tri_color),
    .clear_req   (clear_req),
    .frame_busy  (frame_busy),
    .tri_count   (tri_count),
    .ru_start    (ru_start),
    .ru_p1       (ru_p1),
    .ru_p2       (ru_p2),
    .ru_p3       (ru_p3),
    .ru_color    (ru_color),
    .ru_done     (ru_done),
    .ru_fb_we    (ru_fb_we),
    .ru_zb_we    (ru_zb_we),
    .ru_rast_x   (ru_rast_x),
    .ru_rast_y   (ru_rast_y),
    .ru_fb_data  (ru_fb_data),
    .ru_zb_wdata (ru_zb_wdata),
    .fb_we       (fb_we),
    .zb_we       (zb_we),
    .fb_x        (fb_x),
    .fb_y        (fb_y),
    .fb_data     (fb_data),
    .zb_wdata    (zb_wdata)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_pushed = 0;

  logic [291:0] exp_q [$];
  logic [32:0]  wr_q  [$];
  logic [291:0] exp_tri;
  logic [32:0]  exp_wr;

  localparam logic [31:0] F_NHALF = 32'hBF000000;
  localparam logic [31:0] F_HALF  = 32'h3F000000;
  localparam logic [31:0] F_TENTH = 32'h3DCCCCCD;
  localparam logic [31:0] F_ZERO  = 32'h00000000;

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic flag(input string name, input string what);
    n_checks++;
    $display("FAIL %s: got %s expected none", name, what);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sreset = 1'b1;
    tick();
    tick();
    sreset = 1'b0;
  endtask

  task automatic push_tri(input logic [2:0][31:0] a, input logic [2:0][31:0] b,
                          input logic [2:0][31:0] c, input logic [3:0] col);
    int g = 0;
    tri_valid = 1'b1;
    tri_p1 = a; tri_p2 = b; tri_p3 = c; tri_color = col;
    while (!tri_ready && g < 300) begin tick(); g++; end
    if (g >= 300) flag("push_timeout", "tri_ready stuck low");
    exp_q.push_back({a, b, c, col});
    tick();
    n_pushed++;
    tri_valid = 1'b0;
  endtask

  task automatic wait_start();
    int g = 0;
    while (!ru_start && g < 300) begin tick(); g++; end
    if (g >= 300) flag("start_timeout", "no ru_start");
  endtask

  task automatic pulse_done();
    ru_done = 1'b1;
    tick();
    ru_done = 1'b0;
  endtask

  task automatic queue_clear(input int n);
    for (int k = 0; k < n; k++)
      wr_q.push_back({10'(k % 8), 10'(k / 8), 4'h0, 8'hFF, 1'b1});
  endtask

  task automatic wait_idle();
    int g = 0;
    while (frame_busy && g < 300) begin tick(); g++; end
    if (g >= 300) flag("idle_timeout", "frame_busy stuck high");
  endtask

  // Monitor: every ru_start and every memory write must match the scoreboard head.
  always @(negedge clk) begin
    if (!sreset) begin
      if (ru_start) begin
        if (exp_q.size() == 0) flag("ru_start_unexpected", "ru_start");
        else begin
          exp_tri = exp_q.pop_front();
          chk("ru_triangle", {ru_p1, ru_p2, ru_p3, ru_color}, exp_tri);
        end
      end
      if (fb_we) begin
        if (wr_q.size() == 0) flag("fb_write_unexpected", "fb_we");
        else begin
          exp_wr = wr_q.pop_front();
          chk("clear_pixel", {fb_x, fb_y, fb_data, zb_wdata, zb_we}, exp_wr);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int g;
    int s;
    sreset = 1'b1; tri_valid = 1'b0; clear_req = 1'b0; ru_done = 1'b0;
    tri_p1 = '0; tri_p2 = '0; tri_p3 = '0; tri_color = '0;
    ru_fb_we = 1'b0; ru_zb_we = 1'b0; ru_rast_x = '0; ru_rast_y = '0;
    ru_fb_data = '0; ru_zb_wdata = '0;

    // 1. Single triangle and launch latency
    do_reset();
    chk("rst_tri_ready", tri_ready, 1);
    chk("rst_frame_busy", frame_busy, 0);
    chk("rst_tri_count", tri_count, 0);
    chk("rst_ru_start", ru_start, 0);
    chk("rst_fb_we", fb_we, 0);
    push_tri({F_TENTH, F_HALF, F_NHALF}, {F_TENTH, F_NHALF, F_NHALF},
             {F_TENTH, F_ZERO, F_HALF}, 4'hA);
    chk("t1_busy_after_push", frame_busy, 1);
    tick();
    chk("t1_no_start_e1", ru_start, 0);
    tick();
    chk("t1_start_e2", ru_start, 1);
    tick();
    chk("t1_start_gone_e3", ru_start, 0);
    repeat (46) tick();
    pulse_done();
    chk("t1_tri_count", tri_count, 1);
    chk("t1_idle", frame_busy, 0);

    // 2. Queue fill with a stalled rasterizer
    do_reset();
    n_pushed = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          push_tri({32'h1100_0000 + 32'(i), 32'h1200_0000 + 32'(i), 32'h1300_0000 + 32'(i)},
                   {32'h2100_0000 + 32'(i), 32'h2200_0000 + 32'(i), 32'h2300_0000 + 32'(i)},
                   {32'h3100_0000 + 32'(i), 32'h3200_0000 + 32'(i), 32'h3300_0000 + 32'(i)},
                   4'(i + 1));
      end
      begin
        int gg = 0;
        while (tri_ready && gg < 50) begin tick(); gg++; end
        tick();
        tick();
        chk("fill_ready_low", tri_ready, 0);
        chk("fill_pushed_before_stall", n_pushed, 5);
        for (int k = 0; k < 6; k++) begin
          if (k > 0) wait_start();
          tick();
          tick();
          pulse_done();
        end
      end
    join
    wait_idle();
    chk("fill_tri_count", tri_count, 6);
    chk("fill_all_issued", exp_q.size(), 0);

    // 3. Clear sweep with injected rasterizer writes
    do_reset();
    queue_clear(32);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    g = 0;
    while (!fb_we && g < 20) begin tick(); g++; end
    n = 0;
    while (fb_we && n < 100) begin
      if (n == 1) chk("clear_busy", frame_busy, 1);
      if (n == 5) begin
        ru_fb_we = 1'b1; ru_zb_we = 1'b1; ru_rast_x = 10'h3FF; ru_rast_y = 10'h3FF;
        ru_fb_data = 4'h5; ru_zb_wdata = 8'h33;
      end
      if (n == 20) begin
        ru_fb_we = 1'b0; ru_zb_we = 1'b0; ru_rast_x = '0; ru_rast_y = '0;
        ru_fb_data = '0; ru_zb_wdata = '0;
      end
      n++;
      tick();
    end
    chk("clear_len", n, 32);
    chk("clear_all_written", wr_q.size(), 0);
    chk("clear_idle", frame_busy, 0);

    // 4. Clear deferred during WAIT, merged, ahead of queued triangle
    do_reset();
    push_tri({32'hA1, 32'hA2, 32'hA3}, {32'hA4, 32'hA5, 32'hA6}, {32'hA7, 32'hA8, 32'hA9}, 4'h3);
    wait_start();
    tick();
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    tick();
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    push_tri({32'hB1, 32'hB2, 32'hB3}, {32'hB4, 32'hB5, 32'hB6}, {32'hB7, 32'hB8, 32'hB9}, 4'hC);
    repeat (5) tick();
    chk("defer_busy", frame_busy, 1);
    queue_clear(32);
    pulse_done();
    n = 0;
    g = 0;
    while (!ru_start && g < 200) begin
      if (fb_we) n++;
      tick();
      g++;
    end
    chk("defer_sweep_before_start", n, 32);
    tick();
    pulse_done();
    wait_idle();
    chk("defer_tri_count", tri_count, 2);
    chk("defer_writes_done", wr_q.size(), 0);
    chk("defer_tris_done", exp_q.size(), 0);

    // 5. Reset in the middle of a clear with a queued triangle
    do_reset();
    chk("rst_ru_color_cleared", ru_color, 0);
    queue_clear(10);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tri_valid = 1'b1;
    tri_p1 = {32'hC1, 32'hC2, 32'hC3}; tri_p2 = '0; tri_p3 = '0; tri_color = 4'h7;
    tick();
    tri_valid = 1'b0;
    g = 0;
    while (!(fb_we && fb_x == 10'd2 && fb_y == 10'd1) && g < 100) begin tick(); g++; end
    sreset = 1'b1;
    tick();
    sreset = 1'b0;
    chk("midrst_fb_we", fb_we, 0);
    chk("midrst_idle", frame_busy, 0);
    chk("midrst_tri_count", tri_count, 0);
    chk("midrst_ready", tri_ready, 1);
    chk("midrst_pixels_before", wr_q.size(), 0);
    s = 0;
    repeat (20) begin
      if (ru_start) s++;
      tick();
    end
    chk("midrst_no_start", s, 0);

    // 6. Spurious done and counter wrap
    pulse_done();
    chk("spurious_done_count", tri_count, 0);
    chk("spurious_done_idle", frame_busy, 0);
    force dut.tri_count_q = 16'hFFFF;
    tick();
    release dut.tri_count_q;
    tick();
    chk("wrap_preload", tri_count, 16'hFFFF);
    push_tri({32'hD1, 32'hD2, 32'hD3}, {32'hD4, 32'hD5, 32'hD6}, {32'hD7, 32'hD8, 32'hD9}, 4'hE);
    wait_start();
    tick();
    pulse_done();
    chk("wrap_to_zero", tri_count, 0);
    chk("wrap_tris_done", exp_q.size(), 0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
